// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (receiver and transmitter).
// Contents:
//   state_t    : 2-bit receive FSM encodings ST_IDLE, ST_DATA, ST_PARITY, ST_STOP
//   START_BIT  : line level of the start bit
//   STOP_BIT   : line level of the stop bit
//   IDLE_LEVEL : line level while no frame is in flight
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_shift_in.sv
// Enable-gated right-shift register; serial input enters at the MSB so that,
// after DATA_W shifts of an LSB-first stream, the first bit sits at q[0].
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears q
//   clear : synchronous clear (takes priority over shift)
//   shift : shift one position right this cycle
//   sin   : serial input bit
//   q     : parallel register contents
module serial_shift_in #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic              sin,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (shift) begin
            q <= {sin, q[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/serial_byte_receiver.sv
// Receive side of the serial link: start(0), DATA_W data bits LSB first,
// optional even parity bit, stop(1). rx is sampled only on bit_en ticks.
// Received words are presented through a valid/ack holding register.
// Build option: define SERIAL_RX_PARITY_EN to expect an even-parity bit
// between the data bits and the stop bit.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high; clears all state
//   bit_en     : one-cycle bit-rate tick
//   rx         : serial line, idles high
//   rd_ack     : consumer accepts data (only while data_valid=1)
//   data       : last received word
//   data_valid : data holds an unread word
//   frame_err  : one-cycle pulse, bad stop (or parity); frame discarded
//   overrun    : sticky, a word overwrote an unacked word
//   busy       : FSM not in IDLE
module serial_byte_receiver
    import serial_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic              rx,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              start_det;
    logic              stop_ok;

    assign start_det = bit_en && (state == ST_IDLE) && (rx == START_BIT);

`ifdef SERIAL_RX_PARITY_EN
    logic par_err;
    assign stop_ok = (rx == STOP_BIT) && !par_err;
`else
    assign stop_ok = (rx == STOP_BIT);
`endif

    serial_shift_in #(
        .DATA_W(DATA_W)
    ) u_shift (
        .clk  (clk),
        .reset(reset),
        .clear(start_det),
        .shift(bit_en && (state == ST_DATA)),
        .sin  (rx),
        .q    (shreg)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            // A deliver later in this block overrides this clear.
            if (data_valid && rd_ack) begin
                data_valid <= 1'b0;
            end
            if (bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (rx == START_BIT) begin
                            state <= ST_DATA;
                            cnt   <= '0;
                        end
                    end
                    ST_DATA: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    ST_PARITY: begin
                        // Even parity: data bits plus parity bit XOR to 0.
                        par_err <= ((^shreg) != rx);
                        state   <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (stop_ok) begin
                            data       <= shreg;
                            data_valid <= 1'b1;
                            if (data_valid && !rd_ack) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
